// File: rtl/transport_pkg.sv
// Shared transport definitions: header/trailer bytes, word command tags and the
// parser state encoding used by both the send and receive transport stages.
package transport_pkg;

  localparam logic [7:0] HDR_CTRL  = 8'h40;
  localparam logic [7:0] HDR_AUDIO = 8'h80;
  localparam logic [7:0] TRAILER   = 8'hFF;

  localparam logic [1:0] CMD_IDLE  = 2'b00;
  localparam logic [1:0] CMD_CTRL  = 2'b01;
  localparam logic [1:0] CMD_AUDIO = 2'b10;

  localparam int WORD_W = 18;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CTRL_HI,
    S_CTRL_LO,
    S_PAD,
    S_AUD_HI,
    S_AUD_LO,
    S_TRAILER,
    S_DROP
  } xportState_t;

  function automatic logic [WORD_W-1:0] packWord(input logic [1:0] cmd,
                                                 input logic [7:0] hi,
                                                 input logic [7:0] lo);
    return {cmd, hi, lo};
  endfunction

endpackage

// File: rtl/transport_receive_if.sv
// Byte-in / word-out stream bundle of the receive transport stage.
// master is the receive stage (consumes bytes, produces words); slave is its environment.
interface transport_receive_if;
  logic [7:0]  packetIn;
  logic        packetValid;
  logic [1:0]  cmdOut;
  logic [15:0] dataOut;
  logic        dataValid;
  logic        dataReady;

  modport master (input packetIn, input packetValid, input dataReady,
                  output cmdOut, output dataOut, output dataValid);
  modport slave  (output packetIn, output packetValid, output dataReady,
                  input cmdOut, input dataOut, input dataValid);
endinterface

// File: rtl/rx_word_fifo.sv
// Synchronous first-word-fall-through FIFO for tagged 18-bit words.
// A write into a full FIFO is accepted only when a read happens in the same cycle.
module rx_word_fifo #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 18
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     wrEn,
  input  logic [WIDTH-1:0]         wrData,
  input  logic                     rdEn,
  output logic [WIDTH-1:0]         rdData,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             full;
  logic             doRead;
  logic             doWrite;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign doRead  = rdEn && !empty;
  assign doWrite = wrEn && (!full || doRead);
  assign rdData  = mem[rdPtr];

  always_ff @(posedge clk) begin
    if (doWrite) mem[wrPtr] <= wrData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doWrite) wrPtr <= wrPtr + 1'b1;
      if (doRead)  rdPtr <= rdPtr + 1'b1;
      case ({doWrite, doRead})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/transport_receive.sv
// Receive transport stage: parses fixed-length control/audio packets into tagged words.
// Optional packet statistics outputs are enabled by defining TRANSPORT_RECEIVE_STATS_EN.
module transport_receive
  import transport_pkg::*;
#(
  parameter int packetSize  = 16,
  parameter int FIFO_DEPTH  = 32,
  parameter int GAP_TIMEOUT = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  transport_receive_if.master  bus,
  output logic                 busy,
  output logic                 pktErr,
  output logic                 overflow
`ifdef TRANSPORT_RECEIVE_STATS_EN
  ,
  output logic [15:0]          goodPkts,
  output logic [15:0]          errPkts
`endif
);
  localparam int CNT_W = $clog2(packetSize);
  localparam int GAP_W = $clog2(GAP_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] LAST_IDX        = CNT_W'(packetSize - 1);
  localparam logic [CNT_W-1:0] LAST_SAMPLE_IDX = CNT_W'(packetSize - 2);
  localparam logic [GAP_W-1:0] GAP_LIMIT       = GAP_W'(GAP_TIMEOUT - 1);

  xportState_t           state, stateNext;
  logic [CNT_W-1:0]      byteCnt, byteCntNext;
  logic [GAP_W-1:0]      gapCnt, gapCntNext;
  logic                  lastByte;
  logic                  errNext;
  logic                  pushNext;
  logic [1:0]            pushCmd;
  logic                  loadHi;

  logic [7:0]            hiByte_p0;
  logic                  pushVld_p1;
  logic [WORD_W-1:0]     pushWord_p1;

  logic [WORD_W-1:0]     fifoHead;
  logic                  fifoEmpty;
  logic [$clog2(FIFO_DEPTH):0] fifoCount;
  logic                  pop;

  assign lastByte = (byteCnt == LAST_IDX);

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      byteCnt <= '0;
      gapCnt  <= '0;
    end else begin
      state   <= stateNext;
      byteCnt <= byteCntNext;
      gapCnt  <= gapCntNext;
    end
  end

  always_comb begin
    stateNext   = state;
    byteCntNext = byteCnt;
    gapCntNext  = '0;
    errNext     = 1'b0;
    pushNext    = 1'b0;
    pushCmd     = CMD_IDLE;
    loadHi      = 1'b0;
    if (bus.packetValid) begin
      byteCntNext = lastByte ? '0 : byteCnt + 1'b1;
      case (state)
        S_IDLE: begin
          if (bus.packetIn == HDR_CTRL)       stateNext = S_CTRL_HI;
          else if (bus.packetIn == HDR_AUDIO) stateNext = S_AUD_HI;
          else begin
            stateNext = S_DROP;
            errNext   = 1'b1;
          end
        end
        S_CTRL_HI: begin
          loadHi    = 1'b1;
          stateNext = S_CTRL_LO;
        end
        S_CTRL_LO: begin
          pushNext  = 1'b1;
          pushCmd   = CMD_CTRL;
          stateNext = S_PAD;
        end
        S_AUD_HI: begin
          loadHi    = 1'b1;
          stateNext = S_AUD_LO;
        end
        S_AUD_LO: begin
          pushNext  = 1'b1;
          pushCmd   = CMD_AUDIO;
          stateNext = (byteCnt == LAST_SAMPLE_IDX) ? S_TRAILER : S_AUD_HI;
        end
        S_TRAILER: begin
          stateNext = S_IDLE;
          errNext   = (bus.packetIn != TRAILER);
        end
        default: begin
          // PAD and DROP both just run out the packet
          if (lastByte) stateNext = S_IDLE;
        end
      endcase
    end else if (state != S_IDLE) begin
      if (gapCnt == GAP_LIMIT) begin
        stateNext   = S_IDLE;
        byteCntNext = '0;
        errNext     = 1'b1;
      end else begin
        gapCntNext  = gapCnt + 1'b1;
      end
    end
  end

  // ---- stage p0: high byte capture ----
  always_ff @(posedge clk) begin
    if (loadHi) hiByte_p0 <= bus.packetIn;
  end

  // ---- stage p1: assembled word presented to the FIFO ----
  always_ff @(posedge clk) begin
    pushWord_p1 <= packWord(pushCmd, hiByte_p0, bus.packetIn);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pushVld_p1 <= 1'b0;
      pktErr     <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      pushVld_p1 <= pushNext;
      pktErr     <= errNext;
      if (pushVld_p1 && fifoCount == ($clog2(FIFO_DEPTH)+1)'(FIFO_DEPTH) && !pop)
        overflow <= 1'b1;
    end
  end

  rx_word_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(WORD_W)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .wrEn   (pushVld_p1),
    .wrData (pushWord_p1),
    .rdEn   (bus.dataReady),
    .rdData (fifoHead),
    .empty  (fifoEmpty),
    .count  (fifoCount)
  );

  assign pop           = bus.dataReady && !fifoEmpty;
  assign bus.dataValid = !fifoEmpty;
  assign bus.cmdOut    = fifoEmpty ? CMD_IDLE : fifoHead[17:16];
  assign bus.dataOut   = fifoEmpty ? 16'h0000 : fifoHead[15:0];
  assign busy          = (state != S_IDLE);

`ifdef TRANSPORT_RECEIVE_STATS_EN
  logic goodNext;

  function automatic logic [15:0] satInc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign goodNext = bus.packetValid &&
                    ((state == S_PAD && lastByte) ||
                     (state == S_TRAILER && bus.packetIn == TRAILER));

  always_ff @(posedge clk) begin
    if (reset) begin
      goodPkts <= '0;
      errPkts  <= '0;
    end else begin
      if (goodNext) goodPkts <= satInc(goodPkts);
      if (errNext)  errPkts  <= satInc(errPkts);
    end
  end
`endif

endmodule
